// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring, one quotient bit per clock.
// Special cases (divide by zero, signed overflow) complete in a single cycle.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic        Z_,
  output logic        N
);

  // state | meaning
  // IDLE  | no operation in flight
  // RUN   | iterating, cnt = 0..31
  // DONE  | Result valid this cycle, done pulse
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, dvs;
  logic        op_rem, neg_q, neg_r;

  logic        signed_op, b_zero, ovf, special, accept, last;
  logic [31:0] a_mag, b_mag, spec_res;
  logic [32:0] rem_sh, trial;
  logic [31:0] rem_nxt, quo_nxt, fin_q, fin_r;
  logic        res_load;
  logic [31:0] res_val;

  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && A[31]) ? (~A + 32'd1) : A;
    b_mag     = (signed_op && B[31]) ? (~B + 32'd1) : B;
    b_zero    = (B == 32'd0);
    ovf       = signed_op && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    special   = b_zero || ovf;
    accept    = ((state == IDLE) || (state == DONE)) && start && !flush;
    if (b_zero) spec_res = op[1] ? A : 32'hFFFF_FFFF;
    else        spec_res = op[1] ? 32'd0 : 32'h8000_0000;
  end

  // The shifted partial remainder can need 33 bits when the divisor exceeds 2^31;
  // trial[32] then serves as the borrow/sign of the subtraction.
  always_comb begin
    rem_sh  = {rem, quo[31]};
    trial   = rem_sh - {1'b0, dvs};
    rem_nxt = trial[32] ? rem_sh[31:0] : trial[31:0];
    quo_nxt = {quo[30:0], ~trial[32]};
    fin_q   = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
    fin_r   = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
    last    = (state == RUN) && (cnt == 5'd31);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = special ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      RUN:     if (cnt == 5'd31) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    res_load = !flush && ((accept && special) || last);
    res_val  = (state == RUN) ? (op_rem ? fin_r : fin_q) : spec_res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 5'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      dvs    <= 32'd0;
      op_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      Result <= 32'd0;
      Z_     <= 1'b1;
      N      <= 1'b0;
    end else begin
      if (flush) begin
        cnt <= 5'd0;
      end else if (accept) begin
        cnt    <= 5'd0;
        rem    <= 32'd0;
        quo    <= a_mag;
        dvs    <= b_mag;
        op_rem <= op[1];
        neg_q  <= signed_op && (A[31] ^ B[31]);
        neg_r  <= signed_op && A[31];
      end else if (state == RUN) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + 5'd1;
      end
      if (res_load) begin
        Result <= res_val;
        Z_     <= (res_val == 32'd0);
        N      <= res_val[31];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, handshake, signed/unsigned results,
// special cases, busy-start, flush, reset and back-to-back starts.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        busy, done, Z_, N;
  logic [31:0] Result;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  int n_cmp = 0;
  int n_err = 0;

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .A(A), .B(B), .busy(busy), .done(done), .Result(Result), .Z_(Z_), .N(N)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle start; returns one tick after the accepting edge E0.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded at 40), and busy samples on the way.
  task automatic wait_done(output int k, output int nbusy);
    k = 0; nbusy = 0;
    while (!done && k < 40) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_k);
    int k, nb;
    launch(o, a, b);
    wait_done(k, nb);
    check({tag, "_lat"}, k, exp_k);
    check({tag, "_busy_cycles"}, nb, (exp_k == 32) ? 32 : 0);
    check({tag, "_res"}, Result, exp);
    check({tag, "_z"}, Z_, (exp == 32'd0));
    check({tag, "_n"}, N, exp[31]);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(posedge clk); #1;
    check({tag, "_single_pulse"}, done, 1'b0);
  endtask

  initial begin
    int k, nb;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = OP_DIVU; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", Result, 32'd0);
    check("rst_z", Z_, 1'b1);
    check("rst_n_flag", N, 1'b0);
    rst_n = 1'b1;

    run_op("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 32'd14, 32);
    run_op("remu_100_7",  OP_REMU, 32'd100, 32'd7, 32'd2, 32);
    run_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run_op("div_7_m2",    OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
    run_op("divu_big",    OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32);
    run_op("remu_big",    OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32);
    run_op("divu_by1",    OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32);
    run_op("div_5_0",     OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu_5_0",    OP_REMU, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // start during RUN is ignored
    launch(OP_DIVU, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    op = OP_REMU; A = 32'd50; B = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(k, nb);
    check("busy_start_lat", k + 6, 32);
    check("busy_start_res", Result, 32'd333);
    @(posedge clk); #1;

    // flush at RUN cycle 10
    launch(OP_DIVU, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_done", done, 1'b0);
    wait_done(k, nb);
    check("flush_no_done", done, 1'b0);
    check("flush_busy_cycles", nb, 0);
    check("flush_res_kept", Result, 32'd333);

    // reset mid-RUN
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_res", Result, 32'd0);
    check("midrst_z", Z_, 1'b1);
    rst_n = 1'b1;

    // back-to-back: special-case start accepted in the DONE cycle
    launch(OP_DIVU, 32'd9, 32'd3);
    wait_done(k, nb);
    check("b2b_first_lat", k, 32);
    check("b2b_first_done", done, 1'b1);
    check("b2b_first_res", Result, 32'd3);
    op = OP_DIVU; A = 32'd8; B = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second_done", done, 1'b1);
    check("b2b_second_res", Result, 32'hFFFF_FFFF);
    check("b2b_second_n", N, 1'b1);
    @(posedge clk); #1;
    check("b2b_end_done", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divide/remainder unit for the execute stage, implementing RV32M DIV, DIVU, REM and REMU beside the single-cycle ALU. It uses a radix-2 restoring algorithm: one quotient bit per clock, 32 iterations. A start/busy/done handshake lets hazard control stall the pipeline while the unit runs. It reports Z_ and N flags on its result, with the same meaning as the ALU flags.

## Interface

- No parameters. Width is fixed at 32 bits.
- clk  in  1  Single clock. All state changes on the rising edge.
- rst_n  in  1  Reset, synchronous and active-low.
- start  in  1  Request a division. Sampled only in IDLE or DONE.
- flush  in  1  Pipeline flush. Aborts any operation in flight.
- op  in  2  Operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- A  in  32  Dividend. Sampled with start.
- B  in  32  Divisor. Sampled with start.
- busy  out  1  High while iterating.
- done  out  1  One-cycle pulse when Result is valid.
- Result  out  32  Quotient (DIV/DIVU) or remainder (REM/REMU).
- Z_  out  1  High when Result == 0.
- N  out  1  Equal to Result[31].

## Operation

- States:
  - IDLE: no operation.
  - RUN: iterating, counter 0..31.
  - DONE: result valid for exactly one cycle.
- Reset (rst_n=0 at an edge):
  - state becomes IDLE, counter 0.
  - busy=0, done=0, Result=0, Z_=1, N=0.
  - Reset overrides every other input.
- IDLE or DONE with start=1 and flush=0:
  - Latch op, A and B. Compute sign-adjusted operands.
  - Special cases go directly to DONE:
    - B==0: quotient = 0xFFFFFFFF, remainder = A. Applies to both signed and unsigned ops.
    - Signed op with A==0x80000000 and B==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Otherwise go to RUN with counter=0.
- IDLE or DONE with start=0: go to IDLE.
- RUN, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem − divisor_magnitude, computed 33 bits wide.
  - If trial is non-negative: rem = trial and quo[0]=1. Otherwise restore and set quo[0]=0.
  - After iteration 31 go to DONE.
- Signed ops (DIV, REM):
  - Divide the magnitudes |A| and |B| unsigned.
  - Negate the quotient when A[31]^B[31].
  - The remainder takes the sign of A.
  - |0x80000000| is 0x80000000 as an unsigned magnitude.
- On entry to DONE:
  - Result takes the quotient or remainder selected by op[1].
  - Z_ and N are updated from Result.
  - Result, Z_ and N hold until the next entry to DONE or a reset.
- start while in RUN is ignored. There is no queueing.
- flush=1 in any state:
  - Next state is IDLE. No done pulse.
  - Result, Z_ and N keep their previous values.
  - flush takes priority over start.
- start in the DONE cycle is accepted: back-to-back operations.

## Timing

- Start accepted at edge E0.
- Normal operation:
  - RUN iterations occur at edges E1..E32.
  - busy is high from after E0 until E32, 32 cycles in total.
  - done is high for one cycle, between E32 and E33.
  - Start-to-done latency: 32 cycles.
- Special cases:
  - done is high between E0 and E1. Latency 1.
  - busy never asserts.
- busy and done are never high in the same cycle.
- done lasts exactly one cycle unless a new special-case start is accepted during DONE. In that case done stays high for a second consecutive cycle with the new Result.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

1. **DIVU 100/7.** Expect Result=14, Z_=0, N=0. busy high for exactly 32 cycles; done is a single pulse 32 cycles after start. Repeat with REMU: Result=2.
2. **Signed sign handling.**
   - DIV A=0xFFFFFFF9 (−7), B=2: Result=0xFFFFFFFD (−3), N=1.
   - REM with the same operands: Result=0xFFFFFFFF (−1).
   - DIV 7/−2: Result=0xFFFFFFFD.
3. **Divide by zero.**
   - DIV 5/0: Result=0xFFFFFFFF, with done one cycle after start and busy never high.
   - REMU 5/0: Result=5.
4. **Signed overflow.**
   - DIV 0x80000000/0xFFFFFFFF: Result=0x80000000, N=1, latency 1.
   - REM with the same operands: Result=0, Z_=1.
5. **Flush and busy-start.**
   - Start DIVU 1000/3, then pulse start with other operands during RUN: the second start is ignored and Result=333.
   - Repeat, asserting flush at RUN cycle 10: busy falls next cycle, no done pulse, Result keeps its old value.
6. **Reset and back-to-back.**
   - Drive rst_n=0 mid-RUN: after the next edge busy=0, done=0, Result=0, Z_=1.
   - Start DIVU 9/3, and on its done cycle start DIVU 8/0: done is high for two consecutive cycles, with Result 3 then 0xFFFFFFFF.
